// File: rtl/cfg_commit_scheduler.sv
// Configuration register bank with host/auto-control arbitration, atomic
// shadow-to-active commit and supervised launch of the config transmitter.
module cfg_commit_scheduler #(
  parameter int unsigned A_WIDTH        = 3,
  parameter int unsigned D_WIDTH        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4800,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 CONFIG_EN,
  input  logic                 TX_END,
  output logic                 TX_START,
  input  logic                 RD_EN,
  input  logic [A_WIDTH-1:0]   RD_ADDR,
  output logic [D_WIDTH-1:0]   RD_DATA,
  input  logic                 H_REQ,
  input  logic [A_WIDTH-1:0]   H_ADDR,
  input  logic [D_WIDTH-1:0]   H_DATA,
  output logic                 H_ACK,
  input  logic                 A_REQ,
  input  logic [A_WIDTH-1:0]   A_ADDR,
  input  logic [D_WIDTH-1:0]   A_DATA,
  output logic                 A_ACK,
  output logic                 A_REJ,
  output logic                 DIRTY,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_WIDTH-1:0] COMMIT_CNT
);

  localparam int unsigned DEPTH = 1 << A_WIDTH;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_WARN = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_LAUNCH, ST_WAIT} state_t;

  state_t             state;
  state_t             next_state;
  logic [D_WIDTH-1:0] shadow [DEPTH];
  logic [D_WIDTH-1:0] active [DEPTH];
  logic [DEPTH-1:0]   lock;
  logic [TW-1:0]      tmo_cnt;
  logic               host_win;
  logic               auto_win;
  logic               auto_locked;
  logic               timeout_hit;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next state plus arbitration grants; an ACK high this cycle masks its requester.
  always_comb begin
    next_state  = state;
    host_win    = H_REQ && !H_ACK;
    auto_win    = !host_win && A_REQ && !A_ACK;
    auto_locked = lock[A_ADDR];
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:   if (CONFIG_EN) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_LAUNCH;
      ST_LAUNCH: next_state = ST_WAIT;
      ST_WAIT: begin
        // Flag is raised one cycle ahead so it lands exactly TIMEOUT_CYCLES after launch.
        timeout_hit = !TX_END && (tmo_cnt == T_WARN);
        if (TX_END || tmo_cnt == T_LAST) next_state = ST_IDLE;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_START    <= 1'b0;
      BUSY        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      TX_START <= (next_state == ST_LAUNCH);
      BUSY     <= (next_state != ST_IDLE);
      if (timeout_hit) TIMEOUT_ERR <= 1'b1;
      if (state == ST_LAUNCH) tmo_cnt <= '0;
      else if (state == ST_WAIT && tmo_cnt != T_LAST) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Banks: commit snapshot uses pre-edge shadow; a same-cycle write re-dirties afterwards.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      lock       <= '0;
      DIRTY      <= 1'b0;
      COMMIT_CNT <= '0;
      RD_DATA    <= '0;
      H_ACK      <= 1'b0;
      A_ACK      <= 1'b0;
      A_REJ      <= 1'b0;
    end else begin
      H_ACK <= host_win;
      A_ACK <= auto_win;
      A_REJ <= auto_win && auto_locked;
      if (RD_EN) RD_DATA <= active[RD_ADDR];
      if (state == ST_COMMIT && DIRTY) begin
        for (int i = 0; i < DEPTH; i++) active[i] <= shadow[i];
        lock       <= '0;
        DIRTY      <= 1'b0;
        COMMIT_CNT <= COMMIT_CNT + CNT_WIDTH'(1);
      end
      if (host_win) begin
        shadow[H_ADDR] <= H_DATA;
        lock[H_ADDR]   <= 1'b1;
        DIRTY          <= 1'b1;
      end else if (auto_win && !auto_locked) begin
        shadow[A_ADDR] <= A_DATA;
        DIRTY          <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cfg_commit_scheduler.md
Name: cfg_commit_scheduler

Overview:
- Owns the sensor configuration register bank and sequences each configuration transmission.
- Two requesters share one shadow bank of 8 x 16-bit registers:
  - the I2C host (priority);
  - an auto-exposure/auto-control engine.
- On each configuration-window request it commits shadow to active atomically, then launches the config transmitter and supervises it until it finishes.
- Runs in the system-clock domain (48 MHz), between the I2C slave/AE logic and the config transmitter.

Parameters:
A_WIDTH, 3, register address width (bank depth 2^A_WIDTH = 8)
D_WIDTH, 16, register data width
TIMEOUT_CYCLES, 4800, maximum cycles from TX_START to TX_END before abort (100 us at 48 MHz)
CNT_WIDTH, 8, width of COMMIT_CNT

Ports:
CLOCK  in  1  system clock (48 MHz); all logic on rising edge
RESET_N  in  1  asynchronous, active-low reset
CONFIG_EN  in  1  one-cycle pulse requesting a config window (already synchronous to CLOCK)
TX_END  in  1  one-cycle pulse from config transmitter, transmission complete
TX_START  out  1  one-cycle pulse launching the config transmitter
RD_EN  in  1  transmitter read strobe
RD_ADDR  in  A_WIDTH  transmitter read address
RD_DATA  out  D_WIDTH  active-bank read data
H_REQ  in  1  host write request (level, held until H_ACK)
H_ADDR  in  A_WIDTH  host write address
H_DATA  in  D_WIDTH  host write data
H_ACK  out  1  host write accepted, one-cycle pulse
A_REQ  in  1  auto-control write request (level, held until A_ACK)
A_ADDR  in  A_WIDTH  auto-control write address
A_DATA  in  D_WIDTH  auto-control write data
A_ACK  out  1  auto-control write completed, one-cycle pulse
A_REJ  out  1  with A_ACK: write discarded due to host lock
DIRTY  out  1  shadow differs from active (any write since last commit)
BUSY  out  1  FSM not IDLE
TIMEOUT_ERR  out  1  sticky: TX_END not seen within TIMEOUT_CYCLES
COMMIT_CNT  out  CNT_WIDTH  number of commits performed, wraps

Behaviour:

Reset:
- RESET_N low asynchronously clears:
  - shadow bank, active bank, host-lock mask (8 bits), timeout counter, COMMIT_CNT;
  - all outputs to 0; FSM to IDLE.
- Reset mid-transmission: TX_START is 0 from reset assertion; the FSM is IDLE on release. The transmitter is reset by the same RESET_N.

Arbitration (in every FSM state, including during transmission):
- A requester whose ACK is high this cycle is masked, so a held REQ is never double-written.
- H_REQ && !H_ACK: shadow[H_ADDR] <= H_DATA; lock[H_ADDR] <= 1; DIRTY <= 1; H_ACK = 1 next cycle. The auto requester is not granted this cycle.
- Else A_REQ && !A_ACK:
  - If lock[A_ADDR] = 1: no write; A_ACK = 1 and A_REJ = 1 next cycle.
  - Otherwise: shadow[A_ADDR] <= A_DATA; DIRTY <= 1; A_ACK = 1 (A_REJ = 0) next cycle.
- Latency: request sampled at edge N, ACK high for cycle N+1.
- Worst-case wait for the auto requester is unbounded while H_REQ is continuously re-asserted. Accepted: host traffic is sparse (I2C rate).

FSM:
- IDLE: on CONFIG_EN go to COMMIT.
- COMMIT, one cycle:
  - If DIRTY: active <= shadow (all 8 entries in one edge); lock <= 0; DIRTY <= 0; COMMIT_CNT <= COMMIT_CNT + 1 (wraps at 2^CNT_WIDTH - 1 to 0).
  - If !DIRTY: active unchanged, COMMIT_CNT unchanged.
  - Go to LAUNCH.
- LAUNCH: TX_START = 1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT: count cycles.
  - TX_END: go to IDLE.
  - Counter reaches TIMEOUT_CYCLES - 1 without TX_END: TIMEOUT_ERR <= 1 (sticky until reset); go to IDLE.
- TX_START is issued on every CONFIG_EN, even when nothing changed (the sensor needs a config word every window).
- CONFIG_EN while BUSY is ignored; it is not queued.
- TX_END outside WAIT is ignored.

Commit-cycle write collision:
- A shadow write in the COMMIT cycle is not part of this commit. Snapshot and lock clear use pre-edge values; the new write then sets DIRTY = 1 and its lock bit.

Read port:
- RD_DATA <= active[RD_ADDR] on an edge with RD_EN = 1 (1-cycle latency); otherwise holds.
- Active bank changes only in COMMIT, never during LAUNCH/WAIT, so the transmitter always sees a consistent snapshot.

BUSY is high in COMMIT, LAUNCH and WAIT.

Test Plan:
1. Reset, host writes addr 2 = 0x1234, CONFIG_EN -> H_ACK one cycle after request; DIRTY = 1; COMMIT at CONFIG_EN + 1; TX_START at CONFIG_EN + 2; with RD_EN, addr 2 then reads 0x1234 with 1-cycle latency; COMMIT_CNT = 1; DIRTY = 0.
2. H_REQ and A_REQ same cycle, both addr 5 -> host written (0xAAAA), A_ACK + A_REJ next-next cycle; after commit addr 5 reads 0xAAAA. Auto write to addr 5 after that commit is accepted (A_REJ = 0).
3. Host write during WAIT -> RD_DATA for that address unchanged until the next CONFIG_EN commit; second CONFIG_EN during WAIT produces no extra TX_START.
4. CONFIG_EN with DIRTY = 0 -> TX_START still pulses; COMMIT_CNT unchanged.
5. Withhold TX_END -> TIMEOUT_ERR = 1 exactly 4800 cycles after TX_START; BUSY drops the next cycle; a later CONFIG_EN still launches; the flag stays set until RESET_N.
6. RESET_N low during WAIT; COMMIT_CNT wrap after 256 dirty commits -> outputs 0 immediately; banks read 0; wrap 255 -> 0 observed.
